// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_if
// Description : Bundle of the two client command ports and the ram-side
//               strobe/data port served by ram_arbiter.
//               slave  modport : arbiter view (commands in, acks/ram cmd out)
//               master modport : client/ram view (the opposite directions)
// Revision    : 1.0  initial release
// ============================================================================
interface ram_arbiter_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 16
);
    // client m0
    logic              m0_req;
    logic              m0_wen;
    logic [AWIDTH-1:0] m0_addr;
    logic [DWIDTH-1:0] m0_wdata;
    logic              m0_ack;
    logic              m0_err;
    logic [DWIDTH-1:0] m0_rdata;
    // client m1
    logic              m1_req;
    logic              m1_wen;
    logic [AWIDTH-1:0] m1_addr;
    logic [DWIDTH-1:0] m1_wdata;
    logic              m1_ack;
    logic              m1_err;
    logic [DWIDTH-1:0] m1_rdata;
    // ram side
    logic              ram_en;
    logic              ram_wen;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_wdata;
    logic [DWIDTH-1:0] ram_rdata;
    logic              ram_valid;

    modport slave (
        input  m0_req, m0_wen, m0_addr, m0_wdata,
        output m0_ack, m0_err, m0_rdata,
        input  m1_req, m1_wen, m1_addr, m1_wdata,
        output m1_ack, m1_err, m1_rdata,
        output ram_en, ram_wen, ram_addr, ram_wdata,
        input  ram_rdata, ram_valid
    );

    modport master (
        output m0_req, m0_wen, m0_addr, m0_wdata,
        input  m0_ack, m0_err, m0_rdata,
        output m1_req, m1_wen, m1_addr, m1_wdata,
        input  m1_ack, m1_err, m1_rdata,
        input  ram_en, ram_wen, ram_addr, ram_wdata,
        output ram_rdata, ram_valid
    );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Two-requester round-robin arbiter/sequencer for a single-port
//               ram. Each command takes IDLE -> ISSUE -> WAIT -> DONE, giving
//               one ram_en pulse and one ack pulse per command. A missing
//               ram_valid is turned into an error ack after TIMEOUT cycles.
// Ports       : clk  - clock, everything on posedge
//               rst  - synchronous active-high reset
//               bus  - ram_arbiter_if.slave (client commands, acks, ram port)
// Revision    : 1.0  initial release
// ============================================================================
module ram_arbiter #(
    parameter int DWIDTH  = 16,
    parameter int AWIDTH  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_wait  = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    localparam int              c_cw   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic              r_ptr;       // 1: m1 has priority on the next tie
    logic              r_gnt;       // granted master id for the command in flight
    logic              r_wen;       // latched command direction
    logic [c_cw-1:0]   r_cnt;
    logic              r_ram_en;
    logic              r_ram_wen;
    logic [AWIDTH-1:0] r_ram_addr;
    logic [DWIDTH-1:0] r_ram_wdata;
    logic              r_m0_ack, r_m1_ack;
    logic              r_m0_err, r_m1_err;
    logic [DWIDTH-1:0] r_m0_rdata, r_m1_rdata;

    logic              w_sel;       // winner of the current IDLE cycle
    logic [DWIDTH-1:0] w_cap;       // data returned to the client on valid

    // m1 wins if it is the only requester, or on a tie when it holds priority.
    assign w_sel = bus.m1_req & (~bus.m0_req | r_ptr);
    assign w_cap = r_wen ? '0 : bus.ram_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_ptr       <= 1'b0;
            r_gnt       <= 1'b0;
            r_wen       <= 1'b0;
            r_cnt       <= '0;
            r_ram_en    <= 1'b0;
            r_ram_wen   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_m0_ack    <= 1'b0;
            r_m1_ack    <= 1'b0;
            r_m0_err    <= 1'b0;
            r_m1_err    <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.m0_req | bus.m1_req) begin
                        // Latch the winner's command straight into the ram
                        // output registers so ram_en is high in ISSUE.
                        r_gnt       <= w_sel;
                        r_wen       <= w_sel ? bus.m1_wen : bus.m0_wen;
                        r_ram_en    <= 1'b1;
                        r_ram_wen   <= w_sel ? bus.m1_wen : bus.m0_wen;
                        r_ram_addr  <= w_sel ? bus.m1_addr : bus.m0_addr;
                        r_ram_wdata <= w_sel ? bus.m1_wdata : bus.m0_wdata;
                        r_state     <= c_issue;
                    end
                end
                c_issue: begin
                    r_ram_en  <= 1'b0;
                    r_ram_wen <= 1'b0;
                    r_cnt     <= '0;
                    r_state   <= c_wait;
                end
                c_wait: begin
                    if (bus.ram_valid) begin
                        r_m0_ack   <= ~r_gnt;
                        r_m1_ack   <= r_gnt;
                        r_m0_rdata <= r_gnt ? '0 : w_cap;
                        r_m1_rdata <= r_gnt ? w_cap : '0;
                        r_state    <= c_done;
                    end else if (r_cnt == c_last) begin
                        r_m0_ack <= ~r_gnt;
                        r_m1_ack <= r_gnt;
                        r_m0_err <= ~r_gnt;
                        r_m1_err <= r_gnt;
                        r_state  <= c_done;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_done: begin
                    r_m0_ack   <= 1'b0;
                    r_m1_ack   <= 1'b0;
                    r_m0_err   <= 1'b0;
                    r_m1_err   <= 1'b0;
                    r_m0_rdata <= '0;
                    r_m1_rdata <= '0;
                    r_ptr      <= ~r_gnt;
                    r_state    <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign bus.ram_en    = r_ram_en;
    assign bus.ram_wen   = r_ram_wen;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
    assign bus.m0_ack    = r_m0_ack;
    assign bus.m1_ack    = r_m1_ack;
    assign bus.m0_err    = r_m0_err;
    assign bus.m1_err    = r_m1_err;
    assign bus.m0_rdata  = r_m0_rdata;
    assign bus.m1_rdata  = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Directed bench for ram_arbiter with a behavioural ram and a
//               scoreboard of expected acks (id, err, rdata).
// Revision    : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic        id;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ram_arbiter_if #(.DWIDTH(16), .AWIDTH(16)) bus ();

    ram_arbiter #(.DWIDTH(16), .AWIDTH(16), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural ram: valid one cycle after ram_en, unless stubbed.
    logic        stub = 1'b0;
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        bus.ram_valid <= bus.ram_en & ~stub;
        if (bus.ram_en) begin
            if (bus.ram_wen) mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
            else             bus.ram_rdata <= mem[bus.ram_addr[7:0]];
        end
    end

    // Monitor: ack scoreboard and ram_en pulse bookkeeping.
    logic        prev_en = 1'b0;
    int          en_count = 0;
    int          last_en_cyc = -100;
    logic [15:0] last_en_addr = '0;
    logic        spacing_on = 1'b0;
    always @(negedge clk) begin
        if (bus.ram_en) begin
            check("en_single_cycle", 32'(prev_en), 32'd0);
            if (spacing_on && en_count > 0) check("en_spacing", 32'(cyc - last_en_cyc), 32'd4);
            en_count++;
            last_en_cyc  = cyc;
            last_en_addr = bus.ram_addr;
        end
        prev_en = bus.ram_en;
        if (bus.m0_ack || bus.m1_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_both", 32'(bus.m0_ack & bus.m1_ack), 32'd0);
                check("ack_id", 32'(bus.m1_ack), 32'(e.id));
                if (e.id) begin
                    check("m1_err", 32'(bus.m1_err), 32'(e.err));
                    check("m1_rdata", 32'(bus.m1_rdata), 32'(e.rdata));
                    check("m0_idle", 32'({bus.m0_err, bus.m0_rdata}), 32'd0);
                end else begin
                    check("m0_err", 32'(bus.m0_err), 32'(e.err));
                    check("m0_rdata", 32'(bus.m0_rdata), 32'(e.rdata));
                    check("m1_idle", 32'({bus.m1_err, bus.m1_rdata}), 32'd0);
                end
            end
        end
    end

    task automatic drive(input int id, input logic wen, input logic [15:0] addr, input logic [15:0] wdata);
        if (id == 0) begin
            bus.m0_req = 1'b1; bus.m0_wen = wen; bus.m0_addr = addr; bus.m0_wdata = wdata;
        end else begin
            bus.m1_req = 1'b1; bus.m1_wen = wen; bus.m1_addr = addr; bus.m1_wdata = wdata;
        end
    endtask

    task automatic wait_ack(input int id, input int maxc, output int ack_cyc);
        logic found;
        found   = 1'b0;
        ack_cyc = -1;
        for (int i = 0; i < maxc && !found; i++) begin
            @(posedge clk); #1;
            if ((id == 0 && bus.m0_ack) || (id == 1 && bus.m1_ack)) begin
                found   = 1'b1;
                ack_cyc = cyc;
            end
        end
        if (!found) check("ack_timeout", 32'd0, 32'd1);
    endtask

    int k, ac, ac2, n0, n1, en0;

    initial begin
        bus.m0_req = 0; bus.m0_wen = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
        bus.m1_req = 0; bus.m1_wen = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
        bus.ram_valid = 0; bus.ram_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_acks", 32'({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}), 32'd0);
        check("rst_ram", 32'({bus.ram_en, bus.ram_wen, bus.ram_addr}), 32'd0);
        check("rst_data", 32'({bus.m0_rdata, bus.m1_rdata}), 32'd0);
        rst = 0;
        @(posedge clk); #1;

        // 1: m0 write 0xBEEF -> 0x0010
        k = cyc + 1;
        drive(0, 1'b1, 16'h0010, 16'hBEEF);
        sb.push_back('{id: 1'b0, err: 1'b0, rdata: 16'h0});
        wait_ack(0, 10, ac);
        bus.m0_req = 0;
        check("t1_en_cyc", 32'(last_en_cyc), 32'(k));
        check("t1_en_addr", 32'(last_en_addr), 32'h0010);
        check("t1_ack_cyc", 32'(ac), 32'(k + 2));

        // 2: m1 read 0x0010
        @(posedge clk); #1;
        k = cyc + 1;
        drive(1, 1'b0, 16'h0010, 16'h0);
        sb.push_back('{id: 1'b1, err: 1'b0, rdata: 16'hBEEF});
        wait_ack(1, 10, ac);
        bus.m1_req = 0;
        check("t2_ack_cyc", 32'(ac), 32'(k + 2));

        // 3: both masters continuously, 8 commands, alternating from m0
        @(posedge clk); #1;
        for (int j = 0; j < 4; j++) begin
            sb.push_back('{id: 1'b0, err: 1'b0, rdata: 16'h0});
            sb.push_back('{id: 1'b1, err: 1'b0, rdata: 16'hBEEF});
        end
        en0 = en_count;
        spacing_on = 1'b1;
        n0 = 0; n1 = 0;
        drive(0, 1'b1, 16'h0020, 16'hA000);
        drive(1, 1'b0, 16'h0010, 16'h0);
        for (int i = 0; i < 60 && !(n0 == 4 && n1 == 4); i++) begin
            @(posedge clk); #1;
            if (bus.m0_ack) begin
                n0++;
                if (n0 < 4) drive(0, 1'b1, 16'(16'h0020 + n0), 16'(16'hA000 + n0));
                else        bus.m0_req = 0;
            end
            if (bus.m1_ack) begin
                n1++;
                if (n1 < 4) drive(1, 1'b0, 16'h0010, 16'h0);
                else        bus.m1_req = 0;
            end
        end
        spacing_on = 1'b0;
        check("t3_acks", 32'(n0 + n1), 32'd8);
        check("t3_en_count", 32'(en_count - en0), 32'd8);

        // 4: ram_valid stubbed on m0 read -> error ack, then m1 proceeds
        @(posedge clk); #1;
        stub = 1'b1;
        k = cyc + 1;
        drive(0, 1'b0, 16'h0010, 16'h0);
        sb.push_back('{id: 1'b0, err: 1'b1, rdata: 16'h0});
        wait_ack(0, 40, ac);
        bus.m0_req = 0;
        stub = 1'b0;
        check("t4_timeout_cyc", 32'(ac), 32'(k + 1 + TIMEOUT));
        @(posedge clk); #1;
        k = cyc + 1;
        drive(1, 1'b0, 16'h0020, 16'h0);
        sb.push_back('{id: 1'b1, err: 1'b0, rdata: 16'hA000});
        wait_ack(1, 10, ac);
        bus.m1_req = 0;
        check("t4_next_cyc", 32'(ac), 32'(k + 2));

        // 6: back-to-back m0 write 0x0001 -> 5 then read 5
        @(posedge clk); #1;
        k = cyc + 1;
        en0 = en_count;
        drive(0, 1'b1, 16'h0005, 16'h0001);
        sb.push_back('{id: 1'b0, err: 1'b0, rdata: 16'h0});
        sb.push_back('{id: 1'b0, err: 1'b0, rdata: 16'h0001});
        wait_ack(0, 10, ac);
        drive(0, 1'b0, 16'h0005, 16'h0);
        wait_ack(0, 10, ac2);
        bus.m0_req = 0;
        check("t6_ack1_cyc", 32'(ac), 32'(k + 2));
        check("t6_ack2_cyc", 32'(ac2), 32'(k + 6));
        check("t6_en_count", 32'(en_count - en0), 32'd2);
        check("t6_en2_cyc", 32'(last_en_cyc), 32'(k + 4));

        // 5: reset during WAIT of an m1 read (m1 currently holds priority)
        @(posedge clk); #1;
        drive(1, 1'b0, 16'h0010, 16'h0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.m1_req = 0;
        @(posedge clk); #1;
        check("t5_rst_acks", 32'({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}), 32'd0);
        check("t5_rst_ram", 32'({bus.ram_en, bus.ram_wen, bus.ram_addr}), 32'd0);
        check("t5_rst_data", 32'({bus.ram_wdata, bus.m1_rdata}), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back('{id: 1'b0, err: 1'b0, rdata: 16'h0001});
        sb.push_back('{id: 1'b1, err: 1'b0, rdata: 16'hBEEF});
        drive(0, 1'b0, 16'h0005, 16'h0);
        drive(1, 1'b0, 16'h0010, 16'h0);
        n0 = 0; n1 = 0;
        for (int i = 0; i < 30 && !(n0 == 1 && n1 == 1); i++) begin
            @(posedge clk); #1;
            if (bus.m0_ack) begin n0++; bus.m0_req = 0; end
            if (bus.m1_ack) begin n1++; bus.m1_req = 0; end
        end
        check("t5_served", 32'(n0 + n1), 32'd2);

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
